// File: rtl/fetch_pc_unit.sv
// Instruction-fetch front end: PC register, instruction-memory read
// handshake, IF/ID latch, miss draining, redirect and halt handling.
module fetch_pc_unit #(
    parameter int unsigned          WORD_W  = 32,
    parameter logic [WORD_W-1:0]    PC_INIT = '0
) (
    input  logic                CLK,
    input  logic                RST,
    input  logic                ihit,
    input  logic [WORD_W-1:0]   imemload,
    input  logic                pc_mux,
    input  logic [WORD_W-1:0]   final_memaddr,
    input  logic                pc_cntrl,
    input  logic                halt,
    output logic                imemREN,
    output logic [WORD_W-1:0]   imemaddr_req,
    output logic                if_valid,
    output logic [WORD_W-1:0]   if_instr,
    output logic [WORD_W-1:0]   if_pc,
    output logic [WORD_W-1:0]   if_npc
);

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        DRAIN  = 2'd1,
        HALTED = 2'd2
    } state_t;

    localparam logic [WORD_W-1:0] PC_STEP = WORD_W'(4);

    state_t             state, state_n;
    logic [WORD_W-1:0]  pc, pc_n;
    logic [WORD_W-1:0]  stash, stash_n;
    logic               if_valid_n;
    logic [WORD_W-1:0]  if_instr_n, if_pc_n, if_npc_n;
    logic [WORD_W-1:0]  target;
    logic [WORD_W-1:0]  pc_plus4;

    // Redirect targets are word aligned; PC increment wraps naturally.
    always_comb begin
        target   = {final_memaddr[WORD_W-1:2], 2'b00};
        pc_plus4 = pc + PC_STEP;
    end

    // Next-state and next-register values; priority halt > pc_mux > pc_cntrl > ihit.
    always_comb begin
        state_n    = state;
        pc_n       = pc;
        stash_n    = stash;
        if_valid_n = if_valid;
        if_instr_n = if_instr;
        if_pc_n    = if_pc;
        if_npc_n   = if_npc;
        case (state)
            RUN: begin
                if (halt) begin
                    state_n    = HALTED;
                    if_valid_n = 1'b0;
                end else if (pc_mux) begin
                    if_valid_n = 1'b0;
                    if (ihit) begin
                        pc_n = target;
                    end else begin
                        // Miss in flight: let it finish on the old address.
                        stash_n = target;
                        state_n = DRAIN;
                    end
                end else if (!pc_cntrl && ihit) begin
                    if_instr_n = imemload;
                    if_pc_n    = pc;
                    if_npc_n   = pc_plus4;
                    if_valid_n = 1'b1;
                    pc_n       = pc_plus4;
                end
            end
            DRAIN: begin
                if_valid_n = 1'b0;
                if (halt) begin
                    state_n = HALTED;
                end else if (ihit) begin
                    pc_n    = pc_mux ? target : stash;
                    state_n = RUN;
                end else if (pc_mux) begin
                    stash_n = target;
                end
            end
            HALTED: begin
                if_valid_n = 1'b0;
            end
            default: begin
                state_n = RUN;
            end
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state    <= RUN;
            pc       <= PC_INIT;
            stash    <= '0;
            if_valid <= 1'b0;
            if_instr <= '0;
            if_pc    <= '0;
            if_npc   <= '0;
        end else begin
            state    <= state_n;
            pc       <= pc_n;
            stash    <= stash_n;
            if_valid <= if_valid_n;
            if_instr <= if_instr_n;
            if_pc    <= if_pc_n;
            if_npc   <= if_npc_n;
        end
    end

    // Memory request: the PC is the in-flight address in both RUN and DRAIN.
    always_comb begin
        imemREN      = !RST && (state != HALTED);
        imemaddr_req = pc;
    end

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Scoreboard bench for fetch_pc_unit: directed scenarios followed by
// randomized traffic, checked against a behavioural reference model.
module tb_fetch_pc_unit;

    localparam logic [31:0] PC_INIT = 32'h0000_0000;

    logic        clk;
    logic        rst;
    logic        ihit;
    logic [31:0] imemload;
    logic        pc_mux;
    logic [31:0] final_memaddr;
    logic        pc_cntrl;
    logic        halt;
    logic        imemREN;
    logic [31:0] imemaddr_req;
    logic        if_valid;
    logic [31:0] if_instr;
    logic [31:0] if_pc;
    logic [31:0] if_npc;

    fetch_pc_unit #(.WORD_W(32), .PC_INIT(PC_INIT)) dut (
        .CLK           (clk),
        .RST           (rst),
        .ihit          (ihit),
        .imemload      (imemload),
        .pc_mux        (pc_mux),
        .final_memaddr (final_memaddr),
        .pc_cntrl      (pc_cntrl),
        .halt          (halt),
        .imemREN       (imemREN),
        .imemaddr_req  (imemaddr_req),
        .if_valid      (if_valid),
        .if_instr      (if_instr),
        .if_pc         (if_pc),
        .if_npc        (if_npc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        ren;
        logic        chk_addr;
        logic [31:0] addr;
        logic        valid;
        logic [31:0] instr;
        logic [31:0] pc;
        logic [31:0] npc;
        string       tag;
    } exp_t;

    exp_t sb[$];
    int unsigned total  = 0;
    int unsigned passed = 0;

    // Reference model: a fetcher that is either halted, running, or waiting
    // for an outstanding miss to return before jumping to a remembered target.
    logic        m_halted;
    logic        m_waiting;
    logic [31:0] m_target;
    logic [31:0] m_pc;
    logic        m_valid;
    logic [31:0] m_instr, m_ipc, m_inpc;

    task automatic step(input logic r, input logic h, input logic [31:0] ld,
                        input logic mx, input logic [31:0] fa, input logic st,
                        input logic hl, input string tag);
        exp_t        e;
        logic [31:0] tgt;
        @(negedge clk);
        rst = r; ihit = h; imemload = ld; pc_mux = mx;
        final_memaddr = fa; pc_cntrl = st; halt = hl;
        tgt = fa & 32'hFFFF_FFFC;
        if (r) begin
            m_halted = 0; m_waiting = 0; m_target = 0; m_pc = PC_INIT;
            m_valid = 0; m_instr = 0; m_ipc = 0; m_inpc = 0;
        end else if (m_halted) begin
            m_valid = 0;
        end else if (hl) begin
            m_halted = 1; m_valid = 0;
        end else if (m_waiting) begin
            m_valid = 0;
            if (h) begin
                m_pc = mx ? tgt : m_target;
                m_waiting = 0;
            end else if (mx) begin
                m_target = tgt;
            end
        end else if (mx) begin
            m_valid = 0;
            if (h) m_pc = tgt;
            else begin
                m_waiting = 1; m_target = tgt;
            end
        end else if (!st && h) begin
            m_instr = ld; m_ipc = m_pc; m_inpc = m_pc + 32'd4;
            m_valid = 1; m_pc = m_pc + 32'd4;
        end
        e.ren      = !r && !m_halted;
        e.chk_addr = !m_halted;
        e.addr     = m_pc;
        e.valid    = m_valid;
        e.instr    = m_instr;
        e.pc       = m_ipc;
        e.npc      = m_inpc;
        e.tag      = tag;
        sb.push_back(e);
    endtask

    // Monitor: each clock edge produces one set of outputs to be checked.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                total++;
                if (imemREN === e.ren && (!e.chk_addr || imemaddr_req === e.addr) &&
                    if_valid === e.valid && if_instr === e.instr &&
                    if_pc === e.pc && if_npc === e.npc) begin
                    passed++;
                end else begin
                    $display("FAIL %s t=%0t got ren=%b addr=%h v=%b instr=%h pc=%h npc=%h want ren=%b addr=%h v=%b instr=%h pc=%h npc=%h",
                             e.tag, $time, imemREN, imemaddr_req, if_valid, if_instr, if_pc, if_npc,
                             e.ren, e.addr, e.valid, e.instr, e.pc, e.npc);
                end
            end
        end
    end

    initial begin
        int unsigned wait_cycles;
        rst = 1; ihit = 0; imemload = 0; pc_mux = 0;
        final_memaddr = 0; pc_cntrl = 0; halt = 0;

        // Reset and straight-line fetch
        step(1, 0, 0, 0, 0, 0, 0, "reset");
        step(0, 1, 32'h00A0_0093, 0, 0, 0, 0, "fetch0");
        step(0, 1, 32'h0010_0113, 0, 0, 0, 0, "fetch4");
        // Miss at pc=8 for three cycles then completion
        step(0, 0, 32'hDEAD_0001, 0, 0, 0, 0, "miss1");
        step(0, 0, 32'hDEAD_0002, 0, 0, 0, 0, "miss2");
        step(0, 0, 32'hDEAD_0003, 0, 0, 0, 0, "miss3");
        step(0, 1, 32'h0000_0888, 0, 0, 0, 0, "miss_done");
        // Redirect during miss, newer redirect overrides, drain completes
        step(0, 0, 0, 1, 32'h40, 0, 0, "drain_enter");
        step(0, 0, 0, 1, 32'h82, 1, 0, "drain_restash");
        step(0, 1, 32'hBAD0_BAD0, 0, 0, 0, 0, "drain_exit");
        step(0, 1, 32'h1111_0080, 0, 0, 0, 0, "fetch80");
        // Stall vs redirect
        step(0, 1, 32'h2222_2222, 0, 0, 1, 0, "stall_hit");
        step(0, 1, 32'h3333_3333, 1, 32'h100, 1, 0, "stall_redirect");
        step(0, 1, 32'h4444_0100, 0, 0, 0, 0, "fetch100");
        // Wrap at top of address space
        step(0, 1, 0, 1, 32'hFFFF_FFFF, 0, 0, "to_top");
        step(0, 1, 32'h5555_FFFC, 0, 0, 0, 0, "wrap");
        step(0, 1, 32'h6666_0000, 0, 0, 0, 0, "after_wrap");
        // Reset in the middle of a drain discards the stash
        step(0, 0, 0, 1, 32'h200, 0, 0, "drain_for_rst");
        step(1, 1, 32'h7777_7777, 0, 0, 0, 0, "rst_in_drain");
        step(0, 1, 32'h8888_0000, 0, 0, 0, 0, "post_rst");
        // Halt is sticky until reset
        step(0, 1, 32'h9999_9999, 0, 0, 0, 1, "halt");
        step(0, 1, 32'hAAAA_AAAA, 1, 32'h300, 0, 0, "halted_mux");
        step(0, 1, 32'hBBBB_BBBB, 0, 0, 0, 0, "halted_hit");
        step(1, 0, 0, 0, 0, 0, 0, "halt_rst");
        step(0, 1, 32'hCCCC_0000, 0, 0, 0, 0, "halt_rst_fetch");

        // Randomized traffic
        for (int i = 0; i < 800; i++) begin
            step(($urandom_range(0, 63) == 0),
                 ($urandom_range(0, 9) < 6),
                 $urandom(),
                 ($urandom_range(0, 99) < 15),
                 ($urandom_range(0, 7) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15))) : $urandom(),
                 ($urandom_range(0, 99) < 20),
                 ($urandom_range(0, 99) < 2),
                 "random");
        end

        @(negedge clk);
        ihit = 0; pc_mux = 0; pc_cntrl = 0; halt = 0; rst = 0;
        wait_cycles = 0;
        while (sb.size() > 0 && wait_cycles < 10) begin
            @(negedge clk);
            wait_cycles++;
        end
        if (sb.size() > 0) begin
            total++;
            $display("FAIL drain_scoreboard left=%0d want 0", sb.size());
        end
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
